if_id_pipeline: RTL and testbench

Fetch-to-decode pipeline stage of the LC-3b pipelined datapath. It registers the instruction word and PC returned by the instruction-memory port and presents them to decode, which in turn feeds the ID/EX register. A one-entry skid buffer catches an instruction that arrives while the pipeline is stalled. The stage squashes wrong-path instructions on flush and counts inserted bubbles for performance debug.

---
 rtl/if_id_pipeline_pkg.sv | 19 +
 rtl/if_id_pipeline_if.sv | 27 ++
 rtl/if_id_pipeline_slot.sv | 21 ++
 rtl/if_id_pipeline.sv | 100 ++++++++++
 tb/tb_if_id_pipeline.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/if_id_pipeline_pkg.sv
// Shared LC-3b types: word width, NOP encoding and the fetch packet carried by IF/ID.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  // BR with nzp=000: never taken, so it is a safe filler for empty slots
  localparam lc3b_word LC3B_NOP = 16'h0000;

  typedef struct packed {
    logic     valid;
    lc3b_word ir;
    lc3b_word pc;
  } lc3b_fetch_packet;

  localparam lc3b_fetch_packet LC3B_EMPTY_PACKET = '{valid: 1'b0, ir: LC3B_NOP, pc: 16'h0000};

endpackage

// File: rtl/if_id_pipeline_if.sv
// Fetch/decode-side bundle of the IF/ID stage; clk and reset stay outside.
interface if_id_pipeline_if;
  import lc3b_types::*;

  logic     imem_resp;
  lc3b_word imem_rdata;
  lc3b_word fetch_pc;
  logic     stall_pipeline;
  logic     flush;
  logic     fetch_ready;
  logic     valid_out;
  lc3b_word ir_out;
  lc3b_word pc_out;
  lc3b_word bubble_count;
  logic     skid_overflow;

  modport master (
    output imem_resp, imem_rdata, fetch_pc, stall_pipeline, flush,
    input  fetch_ready, valid_out, ir_out, pc_out, bubble_count, skid_overflow
  );

  modport slave (
    input  imem_resp, imem_rdata, fetch_pc, stall_pipeline, flush,
    output fetch_ready, valid_out, ir_out, pc_out, bubble_count, skid_overflow
  );

endinterface

// File: rtl/if_id_pipeline_slot.sv
// One fetch-packet register with load and clear; reset and clear both empty it.
module if_id_slot
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  lc3b_fetch_packet d,
  output lc3b_fetch_packet q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= LC3B_EMPTY_PACKET;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_pipeline.sv
// IF/ID stage: main slot feeding decode, one-entry skid buffer for stalls,
// flush squash, saturating bubble counter and sticky skid-overflow flag.
module if_id_pipeline
  import lc3b_types::*;
(
  input logic        clk,
  input logic        reset,
  if_id_pipeline_if.slave bus
);

  lc3b_fetch_packet main_q;
  lc3b_fetch_packet skid_q;
  lc3b_fetch_packet main_d;
  lc3b_fetch_packet skid_d;
  lc3b_fetch_packet resp_pkt;
  lc3b_word         resp_pc;
  logic             main_load;
  logic             skid_load;
  logic             bubble_c;
  logic             overflow_c;
  lc3b_word         bubble_count;
  logic             skid_overflow;

  assign resp_pc  = bus.fetch_pc + 16'd2;
  assign resp_pkt = '{valid: 1'b1, ir: bus.imem_rdata, pc: resp_pc};

  // Next-state select; flush leaves every load/event low so slots just clear
  always_comb begin
    main_load  = 1'b0;
    main_d     = main_q;
    skid_load  = 1'b0;
    skid_d     = skid_q;
    bubble_c   = 1'b0;
    overflow_c = 1'b0;
    if (!bus.flush) begin
      if (bus.stall_pipeline) begin
        if (bus.imem_resp) begin
          if (!skid_q.valid) begin
            skid_load = 1'b1;
            skid_d    = resp_pkt;
          end else begin
            overflow_c = 1'b1;
          end
        end
      end else begin
        main_load = 1'b1;
        if (skid_q.valid) begin
          main_d    = skid_q;
          skid_load = 1'b1;
          skid_d    = bus.imem_resp ? resp_pkt : LC3B_EMPTY_PACKET;
        end else begin
          main_d    = bus.imem_resp ? resp_pkt : LC3B_EMPTY_PACKET;
        end
        bubble_c = !main_d.valid;
      end
    end
  end

  if_id_slot u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (bus.flush),
    .d     (main_d),
    .q     (main_q)
  );

  if_id_slot u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (bus.flush),
    .d     (skid_d),
    .q     (skid_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= 16'h0000;
    end else if (bubble_c && (bubble_count != 16'hFFFF)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_overflow <= 1'b0;
    end else if (overflow_c) begin
      skid_overflow <= 1'b1;
    end
  end

  assign bus.fetch_ready   = !skid_q.valid;
  assign bus.valid_out     = main_q.valid;
  assign bus.ir_out        = main_q.ir;
  assign bus.pc_out        = main_q.pc;
  assign bus.bubble_count  = bubble_count;
  assign bus.skid_overflow = skid_overflow;

endmodule

// File: tb/tb_if_id_pipeline.sv
// Randomized and directed bench for if_id_pipeline against a queue-based reference model.
module tb_if_id_pipeline;

  logic clk;
  logic reset;

  if_id_pipeline_if bus ();

  if_id_pipeline dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: what decode currently sees plus a FIFO of waiting instructions
  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } instr_t;

  bit          m_valid;
  logic [15:0] m_ir;
  logic [15:0] m_pc;
  instr_t      m_wait[$];
  int          m_bub;
  bit          m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_show(input bit v, input logic [15:0] ir, input logic [15:0] pc);
    m_valid = v;
    m_ir    = v ? ir : 16'h0000;
    m_pc    = v ? pc : 16'h0000;
  endtask

  task automatic model_step(input bit rst, input bit resp, input logic [15:0] rdata,
                            input logic [15:0] pc, input bit stall, input bit fl);
    instr_t in_i;
    instr_t nx;
    in_i.ir = rdata;
    in_i.pc = pc + 16'd2;
    if (rst || fl) begin
      model_show(1'b0, 16'h0, 16'h0);
      m_wait.delete();
      if (rst) begin
        m_bub = 0;
        m_ovf = 1'b0;
      end
    end else if (stall) begin
      if (resp) begin
        if (m_wait.size() == 0) m_wait.push_back(in_i);
        else m_ovf = 1'b1;
      end
    end else begin
      if (m_wait.size() > 0) begin
        nx = m_wait.pop_front();
        model_show(1'b1, nx.ir, nx.pc);
        if (resp) m_wait.push_back(in_i);
      end else begin
        model_show(resp, in_i.ir, in_i.pc);
      end
      if (!m_valid && m_bub < 65535) m_bub++;
    end
  endtask

  task automatic compare_all();
    check_eq("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check_eq("ir_out", 32'(bus.ir_out), 32'(m_ir));
    check_eq("pc_out", 32'(bus.pc_out), 32'(m_pc));
    check_eq("fetch_ready", 32'(bus.fetch_ready), 32'(m_wait.size() == 0));
    check_eq("bubble_count", 32'(bus.bubble_count), 32'(m_bub));
    check_eq("skid_overflow", 32'(bus.skid_overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit rst, input bit resp, input logic [15:0] rdata,
                       input logic [15:0] pc, input bit stall, input bit fl, input bit cmp);
    reset              = rst;
    bus.imem_resp      = resp;
    bus.imem_rdata     = rdata;
    bus.fetch_pc       = pc;
    bus.stall_pipeline = stall;
    bus.flush          = fl;
    model_step(rst, resp, rdata, pc, stall, fl);
    @(posedge clk);
    #1;
    if (cmp) compare_all();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_bub = 0;
    m_ovf = 1'b0;
    model_show(1'b0, 16'h0, 16'h0);
    reset              = 1'b1;
    bus.imem_resp      = 1'b0;
    bus.imem_rdata     = 16'h0;
    bus.fetch_pc       = 16'h0;
    bus.stall_pipeline = 1'b0;
    bus.flush          = 1'b0;

    // Reset then idle
    cycle(1, 0, 16'h0, 16'h0, 0, 0, 1);
    check_eq("reset_ready", 32'(bus.fetch_ready), 32'd1);
    check_eq("reset_bubbles", 32'(bus.bubble_count), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
    check_eq("idle_bubbles", 32'(bus.bubble_count), 32'd3);
    check_eq("idle_ir", 32'(bus.ir_out), 32'h0000);

    // Streaming
    cycle(0, 1, 16'h1261, 16'h3000, 0, 0, 1);
    check_eq("stream0_ir", 32'(bus.ir_out), 32'h1261);
    check_eq("stream0_pc", 32'(bus.pc_out), 32'h3002);
    cycle(0, 1, 16'h1482, 16'h3002, 0, 0, 1);
    check_eq("stream1_ir", 32'(bus.ir_out), 32'h1482);
    check_eq("stream1_pc", 32'(bus.pc_out), 32'h3004);
    check_eq("stream_bubbles", 32'(bus.bubble_count), 32'd3);

    // Stall with skid, then overflow while still stalled
    cycle(0, 1, 16'h1261, 16'h3000, 0, 0, 1);
    cycle(0, 1, 16'h5A0F, 16'h3004, 1, 0, 1);
    check_eq("stall_ready", 32'(bus.fetch_ready), 32'd0);
    check_eq("stall_hold_ir", 32'(bus.ir_out), 32'h1261);
    cycle(0, 1, 16'h7777, 16'h3006, 1, 0, 1);
    check_eq("ovf_set", 32'(bus.skid_overflow), 32'd1);
    cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
    check_eq("skid_out_ir", 32'(bus.ir_out), 32'h5A0F);
    check_eq("skid_out_pc", 32'(bus.pc_out), 32'h3006);
    check_eq("skid_ready", 32'(bus.fetch_ready), 32'd1);
    check_eq("ovf_sticky", 32'(bus.skid_overflow), 32'd1);

    // Flush with both slots full plus stall and a response
    cycle(0, 1, 16'h2222, 16'h4000, 0, 0, 1);
    cycle(0, 1, 16'h3333, 16'h4002, 1, 0, 1);
    cycle(0, 1, 16'hBEEF, 16'h4004, 1, 1, 1);
    check_eq("flush_valid", 32'(bus.valid_out), 32'd0);
    check_eq("flush_ir", 32'(bus.ir_out), 32'h0000);
    check_eq("flush_ready", 32'(bus.fetch_ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);

    // PC wrap
    cycle(0, 1, 16'h0A0A, 16'hFFFE, 0, 0, 1);
    check_eq("wrap_pc", 32'(bus.pc_out), 32'h0000);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
            16'($urandom), 16'($urandom & 32'hFFFE),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), 1);
    end

    // Bubble saturation: reset, then enough idle cycles to reach and pass FFFF
    cycle(1, 0, 16'h0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) cycle(0, 0, 16'h0, 16'h0, 0, 0, 0);
    check_eq("sat_reach", 32'(bus.bubble_count), 32'hFFFF);
    cycle(0, 0, 16'h0, 16'h0, 0, 0, 1);
    check_eq("sat_hold", 32'(bus.bubble_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
